// File: rtl/max_pool_relu_pkg.sv
// Shared CNN-layer definitions: sequencer state encodings and the ReLU clamp value.
// Latency: none (types/constants only); backpressure: n/a.
package max_pool_relu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } layer_state_e;

    localparam logic [31:0] RELU_ZERO = 32'h0000_0000;

endpackage

// File: rtl/max_pool_relu_pool_window_max.sv
// pool_window_max: max(ReLU(x)) over P*P float words, compared as raw magnitude bits.
// Latency: purely combinational; backpressure: none.
module pool_window_max
    import max_pool_relu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int P          = 2
) (
    input  logic [P*P*DATA_WIDTH-1:0] win_i,
    output logic [DATA_WIDTH-1:0]     max_o
);

    logic [DATA_WIDTH-1:0] elem;

    // Negative words (including -0.0) clamp to +0.0, so after ReLU every candidate
    // has a clear sign bit and an unsigned magnitude compare orders them correctly.
    always_comb begin
        max_o = DATA_WIDTH'(RELU_ZERO);
        elem  = DATA_WIDTH'(RELU_ZERO);
        for (int k = 0; k < P*P; k++) begin
            elem = win_i[k*DATA_WIDTH +: DATA_WIDTH];
            if (elem[DATA_WIDTH-1]) begin
                elem = DATA_WIDTH'(RELU_ZERO);
            end
            if (elem[DATA_WIDTH-2:0] > max_o[DATA_WIDTH-2:0]) begin
                max_o = elem;
            end
        end
    end

endmodule

// File: rtl/max_pool_relu.sv
// Snapshots a conv map on start, then writes one ReLU'd max-pooled window per cycle.
// Latency: N+2 cycles start-to-IDLE, done pulses once; start ignored while busy (no backpressure).
module max_pool_relu
    import max_pool_relu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int H          = 28,
    parameter int W          = 28,
    parameter int P          = 2
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 start,
    input  logic [0:H*W*DATA_WIDTH-1]            convIn,
    output logic [0:(H/P)*(W/P)*DATA_WIDTH-1]    poolOut,
    output logic                                 busy,
    output logic                                 done
);

    localparam int NR    = H / P;
    localparam int NC    = W / P;
    localparam int N     = NR * NC;
    localparam int IDX_W = (N  > 1) ? $clog2(N)  : 1;
    localparam int RW    = (NR > 1) ? $clog2(NR) : 1;
    localparam int CW    = (NC > 1) ? $clog2(NC) : 1;

    layer_state_e                 state_q, state_d;
    logic [IDX_W-1:0]             idx_q, idx_d;
    logic [RW-1:0]                pr_q, pr_d;
    logic [CW-1:0]                pc_q, pc_d;
    logic [0:H*W*DATA_WIDTH-1]    snap_q, snap_d;
    logic [0:N*DATA_WIDTH-1]      pool_q, pool_d;
    logic [P*P*DATA_WIDTH-1:0]    win;
    logic [DATA_WIDTH-1:0]        win_max;

    // Window row/col are tracked as counters alongside idx so no divider is needed.
    always_comb begin
        win = '0;
        for (int i = 0; i < P; i++) begin
            for (int j = 0; j < P; j++) begin
                win[(i*P+j)*DATA_WIDTH +: DATA_WIDTH] =
                    snap_q[((int'(pr_q)*P + i)*W + int'(pc_q)*P + j)*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    pool_window_max #(
        .DATA_WIDTH (DATA_WIDTH),
        .P          (P)
    ) u_window_max (
        .win_i (win),
        .max_o (win_max)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        pr_d    = pr_q;
        pc_d    = pc_q;
        snap_d  = snap_q;
        pool_d  = pool_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    snap_d  = convIn;
                    idx_d   = '0;
                    pr_d    = '0;
                    pc_d    = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                pool_d[int'(idx_q)*DATA_WIDTH +: DATA_WIDTH] = win_max;
                if (idx_q == IDX_W'(N-1)) begin
                    idx_d   = '0;
                    pr_d    = '0;
                    pc_d    = '0;
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                    if (pc_q == CW'(NC-1)) begin
                        pc_d = '0;
                        pr_d = pr_q + RW'(1);
                    end else begin
                        pc_d = pc_q + CW'(1);
                    end
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            pr_q    <= '0;
            pc_q    <= '0;
            snap_q  <= '0;
            pool_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pr_q    <= pr_d;
            pc_q    <= pc_d;
            snap_q  <= snap_d;
            pool_q  <= pool_d;
        end
    end

    assign poolOut = pool_q;

endmodule

// File: tb/tb_max_pool_relu.sv
// Directed bench for max_pool_relu on a 4x4 map with 2x2 pooling (four output slots).
// Table of maps with hand-computed pooled results, plus snapshot, reset-abort and held-start sequences.
module tb_max_pool_relu;

    localparam int DW = 32;
    localparam int H  = 4;
    localparam int W  = 4;
    localparam int P  = 2;

    logic             clk;
    logic             reset;
    logic             start;
    logic [0:511]     convIn;
    logic [0:127]     poolOut;
    logic             busy;
    logic             done;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [0:511] map;
        logic [0:127] exp;
        string        name;
    } vec_t;

    vec_t tbl[4];

    max_pool_relu #(
        .DATA_WIDTH (DW),
        .H          (H),
        .W          (W),
        .P          (P)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .convIn  (convIn),
        .poolOut (poolOut),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [0:511] fill(input logic [31:0] v);
        logic [0:511] m;
        for (int k = 0; k < 16; k++) m[k*32 +: 32] = v;
        return m;
    endfunction

    function automatic logic [0:511] put(input logic [0:511] m, input int r, input int c,
                                         input logic [31:0] v);
        logic [0:511] t;
        t = m;
        t[(r*4+c)*32 +: 32] = v;
        return t;
    endfunction

    function automatic logic [0:127] ex4(input logic [31:0] a, input logic [31:0] b,
                                         input logic [31:0] c, input logic [31:0] d);
        return {a, b, c, d};
    endfunction

    function automatic logic [31:0] slot(input logic [0:127] v, input int k);
        return v[k*32 +: 32];
    endfunction

    // One full run: pulse start, optionally scramble convIn right after capture,
    // track busy/done timing, then compare every slot.
    task automatic run_vec(input logic [0:511] map, input logic [0:127] exp,
                           input logic [0:127] prev, input string name, input bit swap);
        int cyc;
        int busyc;
        int done_at;
        convIn = map;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        if (swap) convIn = fill(32'h4040_0000);
        cyc     = 1;
        busyc   = 0;
        done_at = 0;
        while (cyc < 20 && done_at == 0) begin
            if (busy) busyc++;
            if (cyc == 2) begin
                check({name, " slot0 early"}, slot(poolOut, 0), slot(exp, 0));
                check({name, " slot3 held"},  slot(poolOut, 3), slot(prev, 3));
            end
            if (done) done_at = cyc;
            else begin
                tick();
                cyc++;
            end
        end
        check({name, " done cycle"}, 32'(done_at), 32'd5);
        check({name, " busy cycles"}, 32'(busyc), 32'd4);
        for (int k = 0; k < 4; k++)
            check({name, " slot", string'(8'(48 + k))}, slot(poolOut, k), slot(exp, k));
        tick();
        check({name, " idle busy"}, 32'(busy), 32'd0);
        check({name, " idle done"}, 32'(done), 32'd0);
    endtask

    initial begin
        logic [0:511] m;
        logic [0:127] prev;
        int           seen_done;
        int           ndone;
        int           first_done;
        int           second_done;
        logic         b6;
        logic         b7;

        m = put(fill(32'h3F80_0000), 1, 1, 32'h4040_0000);
        tbl[0] = '{m, ex4(32'h4040_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000), "one_three"};

        m = fill(32'h4000_0000);
        m = put(m, 0, 0, 32'hBF80_0000); m = put(m, 0, 1, 32'hBF80_0000);
        m = put(m, 1, 0, 32'hBF80_0000); m = put(m, 1, 1, 32'hBF80_0000);
        tbl[1] = '{m, ex4(32'h0000_0000, 32'h4000_0000, 32'h4000_0000, 32'h4000_0000), "neg_win0"};

        m = fill(32'h3F80_0000);
        m = put(m, 0, 0, 32'h8000_0000); m = put(m, 0, 1, 32'h0000_0000);
        m = put(m, 1, 0, 32'hBF80_0000); m = put(m, 1, 1, 32'h8000_0000);
        tbl[2] = '{m, ex4(32'h0000_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000), "neg_zero"};

        m = '0;
        m = put(m, 0, 0, 32'h3F80_0000); m = put(m, 0, 1, 32'h4000_0000);
        m = put(m, 1, 0, 32'h4080_0000); m = put(m, 1, 1, 32'h4040_0000);
        m = put(m, 0, 2, 32'hC000_0000); m = put(m, 0, 3, 32'h3F00_0000);
        m = put(m, 1, 2, 32'h3E80_0000); m = put(m, 1, 3, 32'h0000_0001);
        m = put(m, 2, 0, 32'hFF80_0000); m = put(m, 2, 1, 32'h8000_0001);
        m = put(m, 3, 0, 32'hBF80_0000); m = put(m, 3, 1, 32'hFFFF_FFFF);
        m = put(m, 2, 2, 32'h7F80_0000); m = put(m, 2, 3, 32'h0000_0000);
        m = put(m, 3, 2, 32'h7FC0_0000); m = put(m, 3, 3, 32'h4200_0000);
        tbl[3] = '{m, ex4(32'h4080_0000, 32'h3F00_0000, 32'h0000_0000, 32'h7FC0_0000), "mixed"};

        reset  = 1'b1;
        start  = 1'b0;
        convIn = '0;
        tick();
        tick();
        for (int k = 0; k < 4; k++)
            check({"reset slot", string'(8'(48 + k))}, slot(poolOut, k), 32'h0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        reset = 1'b0;
        tick();

        prev = '0;
        for (int i = 0; i < 4; i++) begin
            run_vec(tbl[i].map, tbl[i].exp, prev, tbl[i].name, 1'b0);
            prev = tbl[i].exp;
        end

        // convIn changes right after capture; result must come from the snapshot.
        run_vec(tbl[0].map, tbl[0].exp, prev, "snapshot", 1'b1);

        // Reset during RUN aborts with no done pulse.
        convIn = tbl[1].map;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        tick();
        reset  = 1'b1;
        #1;
        for (int k = 0; k < 4; k++)
            check({"abort slot", string'(8'(48 + k))}, slot(poolOut, k), 32'h0);
        check("abort busy", 32'(busy), 32'd0);
        seen_done = 0;
        for (int c = 0; c < 2; c++) begin
            if (done) seen_done++;
            tick();
        end
        reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (done) seen_done++;
            tick();
        end
        check("abort no done", 32'(seen_done), 32'd0);
        run_vec(tbl[0].map, tbl[0].exp, '0, "post_reset", 1'b0);

        // start held high for 10 sampled edges: two runs, second restarts from IDLE.
        convIn      = tbl[3].map;
        start       = 1'b1;
        ndone       = 0;
        first_done  = 0;
        second_done = 0;
        b6          = 1'b1;
        b7          = 1'b0;
        for (int c = 1; c <= 14; c++) begin
            tick();
            if (c == 10) start = 1'b0;
            if (c == 6) b6 = busy;
            if (c == 7) b7 = busy;
            if (done) begin
                ndone++;
                if (ndone == 1) first_done = c;
                else if (ndone == 2) second_done = c;
            end
        end
        check("hold done count", 32'(ndone), 32'd2);
        check("hold first done", 32'(first_done), 32'd5);
        check("hold second done", 32'(second_done), 32'd11);
        check("hold idle gap busy", 32'(b6), 32'd0);
        check("hold rerun busy", 32'(b7), 32'd1);
        for (int k = 0; k < 4; k++)
            check({"hold slot", string'(8'(48 + k))}, slot(poolOut, k), slot(tbl[3].exp, k));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
